zoom_replicate: RTL and testbench



---
 rtl/zoom_replicate.sv | 104 ++++++++++
 tb/tb_zoom_replicate.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/zoom_replicate.sv
// zoom_replicate: nearest-neighbour upscaler writing a FACTOR x FACTOR block per source pixel
// Ports: clk; reset (sync, active-low); start (level request, loader done);
//   src_rdaddr/src_data source RAM read port; dst_wraddr/dst_data/dst_wren destination
//   RAM write port; busy (frame in progress); done (frame complete, held until start drops).
// Define ZOOM_INVERT_EN to write the photographic negative (255 - pixel) instead of the pixel.
module zoom_replicate #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int FACTOR = 2,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [18:0] src_rdaddr,
  input  logic [7:0]  src_data,
  output logic [18:0] dst_wraddr,
  output logic [7:0]  dst_data,
  output logic        dst_wren,
  output logic        busy,
  output logic        done
);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, WAIT = 3'd2, WRITE = 3'd3, DONE = 3'd4;
  localparam int WW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [18:0] COL_STEP = 19'(FACTOR);
  localparam logic [18:0] ROW_STEP = 19'(SRC_W * FACTOR);
  localparam logic [18:0] BAND_STEP = 19'(SRC_W * FACTOR * FACTOR);
  localparam logic [18:0] LAST_X = 19'(SRC_W - 1);
  localparam logic [18:0] LAST_Y = 19'(SRC_H - 1);
  localparam logic [1:0] LAST_D = 2'(FACTOR - 1);
  localparam logic [WW-1:0] LAST_W = WW'(RD_LAT - 1);
  if (FACTOR < 1 || FACTOR > 4 || RD_LAT < 1 || SRC_W < 1 || SRC_H < 1 ||
      longint'(SRC_W) * SRC_H * FACTOR * FACTOR > 64'd524288) begin : g_bad_params
    $error("zoom_replicate: illegal parameter set");
  end
  logic [2:0] state;
  logic [18:0] sx, sy, band, blk, row;
  logic [1:0] dx, dy;
  logic [WW-1:0] wcnt;
  logic [7:0] cap;
`ifdef ZOOM_INVERT_EN
  assign cap = 8'd255 - src_data;
`else
  assign cap = src_data;
`endif
  assign busy = state == READ || state == WAIT || state == WRITE;
  assign done = state == DONE;
  // band is the destination address of the current source row's first block, blk of the
  // current block, row of the current line inside the block; all advance by additions only
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      {sx, sy, band, blk, row, dx, dy, wcnt} <= '0;
      {src_rdaddr, dst_wraddr, dst_data, dst_wren} <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= READ;
          {sx, sy, band, blk, src_rdaddr} <= '0;
        end
        READ: begin
          state <= WAIT;
          wcnt <= '0;
        end
        WAIT: if (wcnt == LAST_W) begin
          state <= WRITE;
          dst_data <= cap;
          dst_wren <= 1'b1;
          dst_wraddr <= blk;
          row <= blk;
          dx <= 2'd0;
          dy <= 2'd0;
        end else wcnt <= wcnt + WW'(1);
        WRITE: if (dx != LAST_D) begin
          dx <= dx + 2'd1;
          dst_wraddr <= dst_wraddr + 19'd1;
        end else if (dy != LAST_D) begin
          dx <= 2'd0;
          dy <= dy + 2'd1;
          row <= row + ROW_STEP;
          dst_wraddr <= row + ROW_STEP;
        end else begin
          dst_wren <= 1'b0;
          if (sx == LAST_X && sy == LAST_Y) state <= DONE;
          else begin
            state <= READ;
            src_rdaddr <= src_rdaddr + 19'd1;
            if (sx == LAST_X) begin
              sx <= '0;
              sy <= sy + 19'd1;
              band <= band + BAND_STEP;
              blk <= band + BAND_STEP;
            end else begin
              sx <= sx + 19'd1;
              blk <= blk + COL_STEP;
            end
          end
        end
        DONE: if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zoom_replicate.sv
// tb_zoom_replicate: scoreboard bench for zoom_replicate on a small frame
module tb_zoom_replicate;
  localparam int W = 5, H = 3, F = 3, RD = 2;
  localparam int NPIX = W * H;
  localparam int NWR = NPIX * F * F;
  localparam int LAT = 1 + NPIX * (1 + RD + F * F);
  typedef struct {
    logic [18:0] a;
    logic [7:0]  d;
  } wr_t;
  logic clk = 1'b0;
  logic reset, start;
  logic [18:0] src_rdaddr, dst_wraddr;
  logic [7:0] src_data, dst_data;
  logic dst_wren, busy, done;
  logic [7:0] mem [32];
  logic [7:0] pipe [RD];
  wr_t q[$];
  wr_t e;
  int checks = 0, errors = 0, wr_cnt = 0;
  zoom_replicate #(.SRC_W(W), .SRC_H(H), .FACTOR(F), .RD_LAT(RD)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_rdaddr(src_rdaddr), .src_data(src_data),
    .dst_wraddr(dst_wraddr), .dst_data(dst_data), .dst_wren(dst_wren),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pipe[0] <= mem[src_rdaddr[4:0]];
    for (int i = 1; i < RD; i++) pipe[i] <= pipe[i-1];
  end
  assign src_data = pipe[RD-1];
  function automatic logic [7:0] px(input int i);
`ifdef ZOOM_INVERT_EN
    return 8'd255 - mem[i];
`else
    return mem[i];
`endif
  endfunction
  task automatic push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int dy = 0; dy < F; dy++)
          for (int dx = 0; dx < F; dx++)
            q.push_back('{19'((y * F + dy) * W * F + x * F + dx), px(y * W + x)});
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic run_frame(input string tag);
    int n, first_wr;
    n = 0;
    first_wr = -1;
    while (!done && n < LAT + 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #1;
      if (dst_wren && first_wr < 0) first_wr = n;
    end
    chk({tag, "_first_wr"}, first_wr, 2 + RD);
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_queue_left"}, q.size(), 0);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask
  always @(negedge clk) begin
    checks++;
    assert (!(busy && done)) else begin
      errors++;
      $error("FAIL busy_done_excl busy=%b done=%b expected not both", busy, done);
    end
    if (dst_wren) begin
      wr_cnt++;
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write addr=%0d data=%0d expected no write", dst_wraddr, dst_data);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 2;
        assert (dst_wraddr === e.a) else begin
          errors++;
          $error("FAIL wr_addr got=%0d expected=%0d", dst_wraddr, e.a);
        end
        assert (dst_data === e.d) else begin
          errors++;
          $error("FAIL wr_data at %0d got=%0d expected=%0d", e.a, dst_data, e.d);
        end
      end
    end
  end
  initial begin
    int base, n;
    reset = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'((i * 37 + 10) % 256);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_src_rdaddr", src_rdaddr, 0);
    chk("rst_dst_wraddr", dst_wraddr, 0);
    chk("rst_dst_data", dst_data, 0);
    chk("rst_dst_wren", dst_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    push_frame();
    reset = 1'b1;
    run_frame("f1");
    chk("f1_writes", wr_cnt, NWR);
    base = wr_cnt;
    repeat (1000) @(negedge clk);
    chk("hold_no_writes", wr_cnt, base);
    chk("hold_done", done, 1);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("drop_done", done, 0);
    chk("drop_busy", busy, 0);
    start = 1'b1;
    push_frame();
    run_frame("f2");
    chk("f2_writes", wr_cnt, 2 * NWR);
    start = 1'b0;
    @(negedge clk);
    #1;
    start = 1'b1;
    push_frame();
    base = wr_cnt;
    n = 0;
    while (wr_cnt < base + 50 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_reached", wr_cnt, base + 50);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_wren", dst_wren, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_src_rdaddr", src_rdaddr, 0);
    q.delete();
    repeat (2) @(negedge clk);
    push_frame();
    reset = 1'b1;
    run_frame("f3");
    chk("total_writes", wr_cnt, 3 * NWR + 50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
